// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC sequencer (in: clk reset stall op next_ctl; out: upc illegal instr_done retired)
module micro_sequencer #(
    parameter int ADDR_W   = 4,
    parameter int MAX_ADDR = 10,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [6:0]        op,
    input  logic [2:0]        next_ctl,
    output logic [ADDR_W-1:0] upc,
    output logic              illegal,
    output logic              instr_done,
    output logic [CNT_W-1:0]  retired
);
    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] RTYPE = 7'b0110011;
    localparam logic [6:0] ITYPE = 7'b0010011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] BEQ   = 7'b1100011;
    logic [ADDR_W-1:0] nxt;
    logic              trap;
    logic              fin;
    always_comb begin
        nxt  = '0;
        trap = 1'b0;
        fin  = 1'b0;
        case (next_ctl)
            3'b000: begin
                trap = upc >= ADDR_W'(MAX_ADDR);
                nxt  = trap ? '0 : upc + 1'b1;
            end
            3'b001: case (op)
                LW, SW:  nxt = ADDR_W'(2);
                RTYPE:   nxt = ADDR_W'(6);
                ITYPE:   nxt = ADDR_W'(8);
                JAL:     nxt = ADDR_W'(9);
                BEQ:     nxt = ADDR_W'(10);
                default: trap = 1'b1;
            endcase
            3'b010: case (op)
                LW:      nxt = ADDR_W'(3);
                SW:      nxt = ADDR_W'(5);
                default: trap = 1'b1;
            endcase
            3'b011:  fin = 1'b1;
            3'b100:  nxt = ADDR_W'(7);
            default: trap = 1'b1;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            upc        <= '0;
            illegal    <= 1'b0;
            instr_done <= 1'b0;
            retired    <= '0;
        end else begin
            illegal    <= ~stall & trap;
            instr_done <= ~stall & fin;
            if (!stall) begin
                upc     <= nxt;
                retired <= retired + CNT_W'(fin);
            end
        end
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: randomized scoreboard bench for micro_sequencer
module tb_micro_sequencer;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;
    logic clk = 0, reset = 1, stall = 0;
    logic [6:0] op = 0;
    logic [2:0] next_ctl = 0;
    logic [3:0] upc, upc4, ret4;
    logic illegal, instr_done, ill4, done4;
    logic [31:0] retired;
    int checks = 0, failures = 0;
    typedef struct {logic [31:0] upc; logic ill; logic done; logic [31:0] ret;} exp_t;
    exp_t q[$];
    exp_t cur;
    int m_upc = 0;
    logic m_ill = 0, m_done = 0;
    logic [31:0] m_ret = 0;
    logic [2:0] store [0:10];
    int d1 [logic [6:0]];
    int d2 [logic [6:0]];
    logic [6:0] legal [6];
    micro_sequencer dut (.clk(clk), .reset(reset), .stall(stall), .op(op), .next_ctl(next_ctl),
        .upc(upc), .illegal(illegal), .instr_done(instr_done), .retired(retired));
    micro_sequencer #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .stall(stall), .op(op),
        .next_ctl(next_ctl), .upc(upc4), .illegal(ill4), .instr_done(done4), .retired(ret4));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, a, e, $time);
        end
    endtask
    task automatic model(input logic r, input logic s, input logic [6:0] o, input logic [2:0] c);
        int n;
        logic t;
        n = 0;
        t = 0;
        if (r) begin
            m_upc = 0; m_ill = 0; m_done = 0; m_ret = 0;
        end else if (s) begin
            m_ill = 0; m_done = 0;
        end else begin
            case (c)
                3'd0: if (m_upc + 1 > 10) t = 1; else n = m_upc + 1;
                3'd1: if (d1.exists(o)) n = d1[o]; else t = 1;
                3'd2: if (d2.exists(o)) n = d2[o]; else t = 1;
                3'd3: n = 0;
                3'd4: n = 7;
                default: t = 1;
            endcase
            m_done = (c == 3'd3);
            m_ret = m_ret + 32'(m_done);
            m_upc = n;
            m_ill = t;
        end
    endtask
    task automatic step(input logic r, input logic s, input logic [6:0] o, input logic f, input logic [2:0] fc);
        @(negedge clk);
        reset = r;
        stall = s;
        op = o;
        next_ctl = f ? fc : store[m_upc];
        model(r, s, o, next_ctl);
        q.push_back('{32'(m_upc), m_ill, m_done, m_ret});
    endtask
    task automatic instr(input logic [6:0] o);
        int k;
        k = 0;
        do begin
            step(0, 0, o, 0, 0);
            k++;
        end while (m_upc != 0 && k < 20);
        chk("instr_bound", 32'(k < 20), 1);
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk("upc", 32'(upc), cur.upc);
            chk("illegal", 32'(illegal), 32'(cur.ill));
            chk("instr_done", 32'(instr_done), 32'(cur.done));
            chk("retired", retired, cur.ret);
            chk("upc4", 32'(upc4), cur.upc);
            chk("illegal4", 32'(ill4), 32'(cur.ill));
            chk("done4", 32'(done4), 32'(cur.done));
            chk("retired4", 32'(ret4), {28'd0, cur.ret[3:0]});
        end
    end
    initial begin
        logic [6:0] co;
        logic r, s, f;
        store = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd3, 3'd4, 3'd3, 3'd4, 3'd4, 3'd3};
        d1[LW] = 2; d1[SW] = 2; d1[RT] = 6; d1[IT] = 8; d1[JAL] = 9; d1[BEQ] = 10;
        d2[LW] = 3; d2[SW] = 5;
        legal = '{LW, SW, RT, IT, JAL, BEQ};
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        instr(LW);
        instr(RT);
        instr(BEQ);
        instr(7'h7f);
        repeat (3) step(0, 0, SW, 0, 0);
        repeat (3) step(0, 1, SW, 0, 0);
        step(0, 0, SW, 0, 0);
        repeat (4) step(0, 0, LW, 0, 0);
        step(0, 0, LW, 1, 3'b110);
        repeat (2) step(0, 0, BEQ, 0, 0);
        step(0, 0, BEQ, 1, 3'b000);
        repeat (2) step(0, 0, IT, 0, 0);
        step(1, 1, IT, 0, 0);
        repeat (17) instr(RT);
        co = LW;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom % 100) == 0;
            s = ($urandom % 7) == 0;
            f = ($urandom % 20) == 0;
            if (m_upc == 0)
                co = ($urandom % 8 == 0) ? 7'($urandom) : legal[$urandom % 6];
            step(r, s, co, f, 3'($urandom));
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("drain", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
